// File: rtl/ex_alu_stage_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg: shared definitions for the ex_alu_stage execute block.
//   - ALU operation codes (4-bit) as produced by the ALU control decoder
//   - Skid-buffer occupancy state encoding
//   - signed_ovf(): signed overflow detection for ADD/SUB
// Optional feature macro used elsewhere in this slice: ALU_OVERFLOW_TRAP_EN.
// ----------------------------------------------------------------------------
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    // Overflow when the effective operand signs agree but the result sign
    // differs. For SUB the effective sign of b is inverted.
    function automatic logic signed_ovf(input logic is_sub, input logic a_msb,
                                        input logic b_msb, input logic r_msb);
        logic b_eff;
        b_eff = is_sub ? ~b_msb : b_msb;
        return (a_msb == b_eff) && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/ex_alu_stage_if.sv
// ----------------------------------------------------------------------------
// ex_alu_stage_if: valid/ready bus into and out of the execute stage.
//   Input side : in_valid, in_ready, in_alu_op, in_a, in_b, in_rd, in_reg_write
//   Output side: out_valid, out_ready, out_result, out_zero, out_rd,
//                out_reg_write, out_illegal, out_ovf (ALU_OVERFLOW_TRAP_EN only)
//   modport master: environment side (drives inputs, consumes results)
//   modport slave : the execute stage itself
// ----------------------------------------------------------------------------
interface ex_alu_stage_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_alu_op;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic [TAG_W-1:0]  in_rd;
    logic              in_reg_write;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic              out_zero;
    logic [TAG_W-1:0]  out_rd;
    logic              out_reg_write;
    logic              out_illegal;
`ifdef ALU_OVERFLOW_TRAP_EN
    logic              out_ovf;
`endif

    modport master (
`ifdef ALU_OVERFLOW_TRAP_EN
        input  out_ovf,
`endif
        output in_valid, in_alu_op, in_a, in_b, in_rd, in_reg_write, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_rd,
               out_reg_write, out_illegal
    );

    modport slave (
`ifdef ALU_OVERFLOW_TRAP_EN
        output out_ovf,
`endif
        input  in_valid, in_alu_op, in_a, in_b, in_rd, in_reg_write, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_rd,
               out_reg_write, out_illegal
    );

endinterface

// File: rtl/ex_alu_stage_alu_core.sv
// ----------------------------------------------------------------------------
// alu_core: purely combinational ALU.
//   op_i      : 4-bit operation code
//   a_i, b_i  : operands
//   result_o  : result (0 for unknown codes)
//   illegal_o : op_i is not one of the defined codes
//   ovf_o     : signed overflow of ADD/SUB (ALU_OVERFLOW_TRAP_EN only)
// ----------------------------------------------------------------------------
module alu_core
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [3:0]        op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
`ifdef ALU_OVERFLOW_TRAP_EN
    output logic              ovf_o,
`endif
    output logic [DATA_W-1:0] result_o,
    output logic              illegal_o
);

    always_comb begin
        result_o  = '0;
        illegal_o = 1'b0;
        // Codes containing X/Z match no item and fall into the default arm.
        case (op_i)
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_ADD: result_o = a_i + b_i;
            ALU_SUB: result_o = a_i - b_i;
            ALU_SLT: result_o = {{(DATA_W-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            ALU_NOR: result_o = ~(a_i | b_i);
            default: illegal_o = 1'b1;
        endcase
    end

`ifdef ALU_OVERFLOW_TRAP_EN
    always_comb begin
        ovf_o = 1'b0;
        if (op_i == ALU_ADD || op_i == ALU_SUB) begin
            ovf_o = signed_ovf(op_i == ALU_SUB, a_i[DATA_W-1], b_i[DATA_W-1],
                               result_o[DATA_W-1]);
        end
    end
`endif

endmodule

// File: rtl/ex_alu_stage.sv
// ----------------------------------------------------------------------------
// ex_alu_stage: execute stage. Computes the ALU result on the input side and
// registers it into a one-entry output slot backed by a one-entry skid, so
// in_ready is a flop and never follows out_ready combinationally.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : synchronous kill of all held entries (wins over transfers)
//   bus        : ex_alu_stage_if.slave (valid/ready in, valid/ready out)
// Optional: ALU_OVERFLOW_TRAP_EN adds out_ovf and suppresses write-back on
// signed ADD/SUB overflow.
//
//   state    | meaning
//   ST_EMPTY | output slot free, skid free
//   ST_ONE   | output slot full, skid free
//   ST_TWO   | output slot and skid full, in_ready low
// ----------------------------------------------------------------------------
module ex_alu_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    ex_alu_stage_if.slave bus
);

    logic [DATA_W-1:0] core_result;
    logic              core_illegal;
    logic              core_ovf;
    logic              new_zero;
    logic              new_rw;

    alu_core #(.DATA_W(DATA_W)) u_alu_core (
        .op_i      (bus.in_alu_op),
        .a_i       (bus.in_a),
        .b_i       (bus.in_b),
`ifdef ALU_OVERFLOW_TRAP_EN
        .ovf_o     (core_ovf),
`endif
        .result_o  (core_result),
        .illegal_o (core_illegal)
    );

`ifndef ALU_OVERFLOW_TRAP_EN
    assign core_ovf = 1'b0;
`endif

    assign new_zero = (core_result == '0);
    assign new_rw   = bus.in_reg_write & ~core_illegal & ~core_ovf;

    state_t            state_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [DATA_W-1:0] res_q,  sk_res_q;
    logic              zero_q, sk_zero_q;
    logic [TAG_W-1:0]  rd_q,   sk_rd_q;
    logic              rw_q,   sk_rw_q;
    logic              ill_q,  sk_ill_q;
    logic              ovf_q,  sk_ovf_q;

    logic in_xfer;
    logic out_xfer;

    assign in_xfer  = bus.in_valid & in_ready_q;
    assign out_xfer = out_valid_q & bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            zero_q      <= 1'b0;
            rd_q        <= '0;
            rw_q        <= 1'b0;
            ill_q       <= 1'b0;
            ovf_q       <= 1'b0;
            sk_res_q    <= '0;
            sk_zero_q   <= 1'b0;
            sk_rd_q     <= '0;
            sk_rw_q     <= 1'b0;
            sk_ill_q    <= 1'b0;
            sk_ovf_q    <= 1'b0;
        end else if (flush) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        state_q     <= ST_ONE;
                        out_valid_q <= 1'b1;
                        res_q       <= core_result;
                        zero_q      <= new_zero;
                        rd_q        <= bus.in_rd;
                        rw_q        <= new_rw;
                        ill_q       <= core_illegal;
                        ovf_q       <= core_ovf;
                    end
                end
                ST_ONE: begin
                    if (in_xfer && !out_xfer) begin
                        // Output slot is stalled: park the new beat in the skid.
                        state_q    <= ST_TWO;
                        in_ready_q <= 1'b0;
                        sk_res_q   <= core_result;
                        sk_zero_q  <= new_zero;
                        sk_rd_q    <= bus.in_rd;
                        sk_rw_q    <= new_rw;
                        sk_ill_q   <= core_illegal;
                        sk_ovf_q   <= core_ovf;
                    end else if (in_xfer && out_xfer) begin
                        res_q  <= core_result;
                        zero_q <= new_zero;
                        rd_q   <= bus.in_rd;
                        rw_q   <= new_rw;
                        ill_q  <= core_illegal;
                        ovf_q  <= core_ovf;
                    end else if (out_xfer) begin
                        state_q     <= ST_EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                ST_TWO: begin
                    if (out_xfer) begin
                        state_q    <= ST_ONE;
                        in_ready_q <= 1'b1;
                        res_q      <= sk_res_q;
                        zero_q     <= sk_zero_q;
                        rd_q       <= sk_rd_q;
                        rw_q       <= sk_rw_q;
                        ill_q      <= sk_ill_q;
                        ovf_q      <= sk_ovf_q;
                    end
                end
                default: begin
                    state_q     <= ST_EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready      = in_ready_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_result    = res_q;
    assign bus.out_zero      = zero_q;
    assign bus.out_rd        = rd_q;
    assign bus.out_reg_write = rw_q;
    assign bus.out_illegal   = ill_q;
`ifdef ALU_OVERFLOW_TRAP_EN
    assign bus.out_ovf       = ovf_q;
`else
    // Skid/slot overflow flags are constant 0 in this build.
    logic unused_ovf;
    assign unused_ovf = ovf_q ^ sk_ovf_q;
`endif

endmodule

// File: tb/tb_ex_alu_stage.sv
module tb_ex_alu_stage;
    import alu_pkg::*;

    localparam int DW = 32;
    localparam int TW = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    ex_alu_stage_if #(.DATA_W(DW), .TAG_W(TW)) bus ();

    ex_alu_stage #(.DATA_W(DW), .TAG_W(TW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int n_out  = 0;

    typedef struct {
        logic [DW-1:0] res;
        logic          zero;
        logic [TW-1:0] rd;
        logic          rw;
        logic          ill;
        logic          ovf;
    } exp_t;

    exp_t sb[$];

    logic act_ovf;
`ifdef ALU_OVERFLOW_TRAP_EN
    assign act_ovf = bus.out_ovf;
`else
    assign act_ovf = 1'b0;
`endif

    function automatic exp_t model(input logic [3:0] op, input logic [DW-1:0] a,
                                   input logic [DW-1:0] b, input logic [TW-1:0] rd,
                                   input logic rw);
        exp_t   e;
        longint s;
        e.res = '0;
        e.ill = 1'b0;
        e.ovf = 1'b0;
        s     = 0;
        case (op)
            4'b0000: e.res = a & b;
            4'b0001: e.res = a | b;
            4'b0010: begin e.res = a + b; s = longint'($signed(a)) + longint'($signed(b)); end
            4'b0110: begin e.res = a - b; s = longint'($signed(a)) - longint'($signed(b)); end
            4'b0111: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1100: e.res = ~(a | b);
            default: e.ill = 1'b1;
        endcase
`ifdef ALU_OVERFLOW_TRAP_EN
        e.ovf = (s > longint'(32'h7FFF_FFFF)) || (s < -longint'(64'h8000_0000));
`endif
        e.zero = (e.res == '0);
        e.rd   = rd;
        e.rw   = rw & ~e.ill & ~e.ovf;
        return e;
    endfunction

    // Scoreboard: pop on every output transfer, push on every accepted input.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (bus.out_valid && bus.out_ready) begin
                n_out++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL out_beat: unexpected beat result=%h rd=%0d, required no beat",
                             bus.out_result, bus.out_rd);
                end else begin
                    e = sb.pop_front();
                    if ({bus.out_result, bus.out_zero, bus.out_rd, bus.out_reg_write,
                         bus.out_illegal, act_ovf} !==
                        {e.res, e.zero, e.rd, e.rw, e.ill, e.ovf}) begin
                        errors++;
                        $display("FAIL out_beat: got res=%h z=%b rd=%0d rw=%b ill=%b ovf=%b, required res=%h z=%b rd=%0d rw=%b ill=%b ovf=%b",
                                 bus.out_result, bus.out_zero, bus.out_rd, bus.out_reg_write,
                                 bus.out_illegal, act_ovf, e.res, e.zero, e.rd, e.rw, e.ill, e.ovf);
                    end
                end
            end
            if (flush)
                sb.delete();
            else if (bus.in_valid && bus.in_ready)
                sb.push_back(model(bus.in_alu_op, bus.in_a, bus.in_b, bus.in_rd,
                                   bus.in_reg_write));
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [TW-1:0] rd, input logic rw);
        int n;
        n = 0;
        bus.in_valid     = 1'b1;
        bus.in_alu_op    = op;
        bus.in_a         = a;
        bus.in_b         = b;
        bus.in_rd        = rd;
        bus.in_reg_write = rw;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=%b, required 1", bus.in_ready);
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #1 n++;
        end while (sb.size() != 0 && n < 100);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d beats still pending, required 0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL reset_hs: got out_valid=%b in_ready=%b, required 0 1",
                     bus.out_valid, bus.in_ready);
        end
        checks++;
        if ({bus.out_result, bus.out_zero, bus.out_rd, bus.out_reg_write, bus.out_illegal,
             act_ovf} !== '0) begin
            errors++;
            $display("FAIL reset_fields: got res=%h z=%b rd=%0d rw=%b ill=%b, required all 0",
                     bus.out_result, bus.out_zero, bus.out_rd, bus.out_reg_write, bus.out_illegal);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_add();
        bus.out_ready = 1'b1;
        send(ALU_ADD, 32'd7, 32'd5, 5'd3, 1'b1);
        @(negedge clk);
        checks++;
        if ({bus.out_valid, bus.out_result, bus.out_zero} !== {1'b1, 32'd12, 1'b0}) begin
            errors++;
            $display("FAIL add_latency: got v=%b res=%0d z=%b, required v=1 res=12 z=0",
                     bus.out_valid, bus.out_result, bus.out_zero);
        end
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic test_slt_sub();
        bus.out_ready = 1'b1;
        send(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 5'd4, 1'b1);
        @(negedge clk);
        checks++;
        if (bus.out_result !== 32'd1) begin
            errors++;
            $display("FAIL slt: got %h, required 00000001", bus.out_result);
        end
        @(posedge clk);
        #1;
        send(ALU_SUB, 32'd9, 32'd9, 5'd6, 1'b1);
        @(negedge clk);
        checks++;
        if ({bus.out_result, bus.out_zero} !== {32'd0, 1'b1}) begin
            errors++;
            $display("FAIL sub_zero: got res=%h z=%b, required 0 1", bus.out_result, bus.out_zero);
        end
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic test_logic_ops();
        bus.out_ready = 1'b1;
        send(ALU_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd1, 1'b1);
        send(ALU_OR,  32'hF000_0001, 32'h000F_0010, 5'd2, 1'b0);
        send(ALU_NOR, 32'h1234_5678, 32'h0000_FFFF, 5'd3, 1'b1);
        send(ALU_SLT, 32'd3, 32'hFFFF_FFFE, 5'd4, 1'b1);
        drain();
    endtask

    task automatic test_illegal();
        bus.out_ready = 1'b1;
        send(4'b1111, 32'd5, 32'd6, 5'd9, 1'b1);
        @(negedge clk);
        checks++;
        if ({bus.out_illegal, bus.out_result, bus.out_reg_write, bus.out_zero} !==
            {1'b1, 32'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL illegal: got ill=%b res=%h rw=%b z=%b, required 1 0 0 1",
                     bus.out_illegal, bus.out_result, bus.out_reg_write, bus.out_zero);
        end
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic test_back_to_back();
        int n0;
        bus.out_ready = 1'b0;
        send(ALU_ADD, 32'd1, 32'd2, 5'd1, 1'b1);
        send(ALU_OR, 32'h10, 32'h01, 5'd2, 1'b1);
        @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.out_valid} !== 2'b01) begin
            errors++;
            $display("FAIL bp_full: got in_ready=%b out_valid=%b, required 0 1",
                     bus.in_ready, bus.out_valid);
        end
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b1;
        bus.in_alu_op = ALU_SUB;
        bus.in_a      = 32'd100;
        bus.in_b      = 32'd1;
        bus.in_rd     = 5'd3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.in_ready, bus.out_valid, bus.out_result, bus.out_rd} !==
                {1'b0, 1'b1, 32'd3, 5'd1}) begin
                errors++;
                $display("FAIL bp_stable: got rdy=%b v=%b res=%h rd=%0d, required 0 1 3 1",
                         bus.in_ready, bus.out_valid, bus.out_result, bus.out_rd);
            end
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        n0 = n_out;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (n_out - n0 !== 3) begin
            errors++;
            $display("FAIL bp_release: got %0d beats in 3 cycles, required 3", n_out - n0);
        end
        drain();
    endtask

    task automatic test_flush();
        int n0;
        bus.out_ready = 1'b0;
        // Flush in ONE with an acceptable beat presented: the beat is discarded.
        send(ALU_ADD, 32'd10, 32'd20, 5'd4, 1'b1);
        bus.in_valid  = 1'b1;
        bus.in_alu_op = ALU_AND;
        bus.in_a      = 32'hFFFF_FFFF;
        bus.in_b      = 32'hFFFF_FFFF;
        bus.in_rd     = 5'd31;
        flush         = 1'b1;
        @(posedge clk);
        #1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL flush_one: got out_valid=%b in_ready=%b, required 0 1",
                     bus.out_valid, bus.in_ready);
        end
        @(posedge clk);
        #1;
        // Flush in TWO together with in_valid.
        send(ALU_ADD, 32'd30, 32'd40, 5'd5, 1'b1);
        send(ALU_ADD, 32'd50, 32'd60, 5'd6, 1'b1);
        bus.in_valid = 1'b1;
        flush        = 1'b1;
        @(posedge clk);
        #1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL flush_two: got out_valid=%b in_ready=%b, required 0 1",
                     bus.out_valid, bus.in_ready);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        n0 = n_out;
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (n_out !== n0) begin
            errors++;
            $display("FAIL flush_ghost: got %0d beats after flush, required 0", n_out - n0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_async_reset();
        bus.out_ready = 1'b0;
        send(ALU_OR, 32'h55, 32'hAA, 5'd7, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.out_valid, bus.in_ready, bus.out_result, bus.out_rd, bus.out_reg_write} !==
            {1'b0, 1'b1, 32'd0, 5'd0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: got v=%b rdy=%b res=%h rd=%0d rw=%b, required 0 1 0 0 0",
                     bus.out_valid, bus.in_ready, bus.out_result, bus.out_rd, bus.out_reg_write);
        end
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        logic [3:0] ops [7];
        bit         done;
        ops  = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR, 4'b1010};
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    send(ops[$urandom_range(0, 6)],
                         ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : 32'($urandom),
                         ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : 32'($urandom),
                         5'($urandom), 1'($urandom));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 bus.out_ready = 1'($urandom);
                end
            end
        join
        bus.out_ready = 1'b1;
        drain();
    endtask

`ifdef ALU_OVERFLOW_TRAP_EN
    task automatic test_ovf();
        bus.out_ready = 1'b1;
        send(ALU_ADD, 32'h7FFF_FFFF, 32'd1, 5'd8, 1'b1);
        @(negedge clk);
        checks++;
        if ({bus.out_ovf, bus.out_result, bus.out_reg_write} !== {1'b1, 32'h8000_0000, 1'b0}) begin
            errors++;
            $display("FAIL ovf_add: got ovf=%b res=%h rw=%b, required 1 80000000 0",
                     bus.out_ovf, bus.out_result, bus.out_reg_write);
        end
        @(posedge clk);
        #1;
        send(ALU_SUB, 32'h8000_0000, 32'd1, 5'd9, 1'b1);
        send(ALU_ADD, 32'd1, 32'd1, 5'd10, 1'b1);
        drain();
    endtask
`endif

    initial begin
        bus.in_valid     = 1'b0;
        bus.in_alu_op    = 4'b0000;
        bus.in_a         = '0;
        bus.in_b         = '0;
        bus.in_rd        = '0;
        bus.in_reg_write = 1'b0;
        bus.out_ready    = 1'b0;

        test_reset();
        test_add();
        test_slt_sub();
        test_logic_ops();
        test_illegal();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_random();
`ifdef ALU_OVERFLOW_TRAP_EN
        test_ovf();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
